// File: rtl/ps2_direction_decoder.sv
// ---------------------------------------------------------------------------
// ps2_direction_decoder
//
// Purpose:
//   Receives PS/2 keyboard frames and turns extended arrow-key make codes
//   into the 2-bit snake direction used by game_logic. The block drops break
//   codes, non-arrow keys and malformed frames. It also refuses any
//   180-degree reversal, so the snake can never turn back into itself.
//
// Ports:
//   clk        in   1  system clock (pixel clock domain of game_logic)
//   reset      in   1  asynchronous, active-high reset
//   ps2_clk    in   1  raw PS/2 clock pin (asynchronous, idle high)
//   ps2_data   in   1  raw PS/2 data pin (asynchronous, idle high)
//   direction  out  2  current direction (LEFT/TOP/RIGHT/DOWN encoding below)
//   dir_valid  out  1  1-cycle pulse in the cycle direction takes a new value
//   frame_err  out  1  1-cycle pulse on parity, stop-bit or timeout error
//
// Direction encoding (matches game_logic):
//   LEFT = 2'd0, TOP = 2'd1, RIGHT = 2'd2, DOWN = 2'd3
// ---------------------------------------------------------------------------
module ps2_direction_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] direction,
  output logic       dir_valid,
  output logic       frame_err
);

  // Direction codes shared with game_logic.
  localparam logic [1:0] LEFT_DIR  = 2'd0;
  localparam logic [1:0] TOP_DIR   = 2'd1;
  localparam logic [1:0] RIGHT_DIR = 2'd2;
  localparam logic [1:0] DOWN_DIR  = 2'd3;

  // Scan-code set 2 bytes of interest.
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_DOWN  = 8'h72;

  // The timeout counter only has to reach TIMEOUT_CYCLES-1.
  localparam int              CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Odd parity: the eight data bits plus the parity bit contain an odd
  // number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Returns {hit, dir}. hit is set when code is one of the four arrow keys.
  function automatic logic [2:0] arrow_lookup(input logic [7:0] code);
    logic [2:0] res;
    res = 3'b000;
    case (code)
      CODE_LEFT:  res = {1'b1, LEFT_DIR};
      CODE_UP:    res = {1'b1, TOP_DIR};
      CODE_RIGHT: res = {1'b1, RIGHT_DIR};
      CODE_DOWN:  res = {1'b1, DOWN_DIR};
      default:    res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    logic [1:0] res;
    res = RIGHT_DIR;
    case (d)
      LEFT_DIR:  res = RIGHT_DIR;
      RIGHT_DIR: res = LEFT_DIR;
      TOP_DIR:   res = DOWN_DIR;
      DOWN_DIR:  res = TOP_DIR;
      default:   res = RIGHT_DIR;
    endcase
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Input synchronisers and falling-edge detection
  // -------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic fall_edge;

  // Both pins idle high, so the flops reset to 1. This stops reset release
  // from being seen as a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_s2_q;

  // -------------------------------------------------------------------------
  // Frame receiver FSM with inter-edge timeout
  // -------------------------------------------------------------------------
  rx_state_t        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             tmo_fire;

  assign tmo_fire = (state_q != S_IDLE) && (tmo_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      rx_byte_q    <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // Count clk cycles between PS/2 edges. The counter is held at zero
    // while idle, so a quiet bus never raises an error.
    if ((state_q == S_IDLE) || fall_edge) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    // A timeout takes priority over an edge in the same cycle. The partial
    // frame is abandoned. The decoder's prefix state is left as it was.
    if (tmo_fire) begin
      state_d     = S_IDLE;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end else if (fall_edge) begin
      case (state_q)
        S_IDLE: begin
          // A high level here is not a start bit, so the edge is ignored.
          if (!data_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
          end
        end
        S_DATA: begin
          // LSB arrives first; each new bit enters at the top and moves down.
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          parity_d = data_s2_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (parity_ok(shift_q, parity_q) && data_s2_q) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shift_q;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Scan-code decoder and direction register
  // -------------------------------------------------------------------------
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [1:0] dir_q, dir_d;
  logic       dir_valid_q, dir_valid_d;
  logic [2:0] arrow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      dir_q       <= RIGHT_DIR;
      dir_valid_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
    end
  end

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    dir_d       = dir_q;
    dir_valid_d = 1'b0;
    arrow       = arrow_lookup(rx_byte_q);

    if (byte_valid_q) begin
      if (rx_byte_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == CODE_BREAK) begin
        brk_d = 1'b1;
      end else begin
        // Any other byte ends the prefix sequence, whether or not it is used.
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Only an extended make code counts. A key press that repeats the
        // current heading or reverses it is dropped without a pulse.
        if (ext_q && !brk_q && arrow[2] &&
            (arrow[1:0] != dir_q) &&
            (arrow[1:0] != opposite_dir(dir_q))) begin
          dir_d       = arrow[1:0];
          dir_valid_d = 1'b1;
        end
      end
    end
  end

  assign direction = dir_q;
  assign dir_valid = dir_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
module tb_ps2_direction_decoder;

  localparam int TMO = 600;

  localparam logic [1:0] LEFT  = 2'd0;
  localparam logic [1:0] TOP   = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;
  localparam logic [1:0] DOWN  = 2'd3;

  // Event kinds pushed into the scoreboard.
  localparam int EV_NONE = 0;
  localparam int EV_DIR  = 1;
  localparam int EV_ERR  = 2;

  // Cycles from the pin fall of the stop bit to the sampled output.
  // 2 synchroniser stages + 1 receiver register (+1 decoder register).
  localparam int LAT_ERR = 3;
  localparam int LAT_DIR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] direction;
  logic       dir_valid;
  logic       frame_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [1:0] dir;
    int         cyc;
    bit         lat;
  } ev_t;

  ev_t exp_q[$];

  ps2_direction_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .direction (direction),
    .dir_valid (dir_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expected event for every output pulse it sees.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (dir_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected dir_valid: direction=%0d at cycle %0d, none expected", direction, cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event kind (dir_valid)", e.kind, EV_DIR);
          check("direction on dir_valid", direction, e.dir);
          if (e.lat) check("dir_valid latency cycle", cyc, e.cyc);
        end
      end
      if (frame_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected frame_err at cycle %0d, none expected", cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event kind (frame_err)", e.kind, EV_ERR);
          if (e.lat) check("frame_err latency cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic push_ev(input int kind, input logic [1:0] dir, input int at, input bit lat);
    ev_t e;
    e.kind = kind;
    e.dir  = dir;
    e.cyc  = at;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  // One PS/2 bit. When kind is not EV_NONE, the expected response is queued
  // at the moment the clock pin falls.
  task automatic send_bit(input logic v, input int kind, input logic [1:0] dir);
    @(negedge clk);
    ps2_data = v;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    if (kind == EV_DIR) push_ev(EV_DIR, dir, cyc + LAT_DIR, 1'b1);
    if (kind == EV_ERR) push_ev(EV_ERR, dir, cyc + LAT_ERR, 1'b1);
    repeat (15) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int kind,
                            input logic [1:0] dir);
    send_bit(1'b0, EV_NONE, 2'd0);
    for (int i = 0; i < 8; i++) send_bit(b[i], EV_NONE, 2'd0);
    send_bit((~^b) ^ flip_par, EV_NONE, 2'd0);
    send_bit(1'b1, kind, dir);
    ps2_data = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, EV_NONE, 2'd0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], EV_NONE, 2'd0);
    ps2_data = 1'b1;
  endtask

  // Gives the monitor time to see any late or extra pulse. Then it requires
  // that every expected event was consumed.
  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset direction", direction, RIGHT);
    check("reset dir_valid", dir_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post-reset direction", direction, RIGHT);

    // 1: LEFT is the opposite of RIGHT, so it is blocked.
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h6B, 1'b0, EV_NONE, 2'd0);
    drain("t1 no pulse on reversal");
    check("t1 direction", direction, RIGHT);

    // 2: TOP is accepted. Then the break sequence and a repeat of the same
    // key are both ignored.
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h75, 1'b0, EV_DIR, TOP);
    drain("t2 top pulse");
    check("t2 direction", direction, TOP);
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'hF0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h75, 1'b0, EV_NONE, 2'd0);
    drain("t2 break ignored");
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h75, 1'b0, EV_NONE, 2'd0);
    drain("t2 same direction ignored");
    check("t2 direction held", direction, TOP);

    // 3: A parity error gives a frame_err. Then LEFT is accepted from TOP.
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h74, 1'b1, EV_ERR, 2'd0);
    drain("t3 parity error");
    check("t3 direction after error", direction, TOP);
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h6B, 1'b0, EV_DIR, LEFT);
    drain("t3 left pulse");
    check("t3 direction", direction, LEFT);

    // 4: Codes without the E0 prefix and non-arrow extended codes are ignored.
    send_frame(8'h75, 1'b0, EV_NONE, 2'd0);
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h1C, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h72, 1'b0, EV_NONE, 2'd0);
    drain("t4 non-arrow ignored");
    check("t4 direction", direction, LEFT);

    // 5: A partial frame times out. The next full frame is accepted.
    send_partial(8'h72, 5);
    push_ev(EV_ERR, 2'd0, 0, 1'b0);
    repeat (TMO + 50) @(negedge clk);
    drain("t5 timeout error");
    check("t5 direction after timeout", direction, LEFT);
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h72, 1'b0, EV_DIR, DOWN);
    drain("t5 down pulse");
    check("t5 direction", direction, DOWN);

    // 6: Reset mid-frame. The trailing bits of 0xF0 plus its parity and stop
    // bits are all 1, so none of them can look like a start bit.
    send_bit(1'b0, EV_NONE, 2'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, EV_NONE, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6 direction at reset", direction, RIGHT);
    check("t6 frame_err at reset", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'b1, EV_NONE, 2'd0);
    drain("t6 leftover bits ignored");
    check("t6 direction after reset", direction, RIGHT);
    send_frame(8'hE0, 1'b0, EV_NONE, 2'd0);
    send_frame(8'h75, 1'b0, EV_DIR, TOP);
    drain("t6 top pulse after reset");
    check("t6 direction final", direction, TOP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
